// File: rtl/johnson_phase_monitor.sv
// Qualifies the code of an upstream 4-bit Johnson counter: phase decode, successor check, lock/fault FSM.
// Optional revolution counter built when JOHNSON_PHASE_MONITOR_WRAPCNT_EN is defined.
module johnson_phase_monitor (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       enable_i,
  input  logic       clear_i,
  input  logic [3:0] count_i,
  output logic       valid_o,
  output logic [2:0] phase_o,
  output logic [7:0] phase_onehot_o,
  output logic       illegal_o,
  output logic       seq_err_o,
  output logic       lock_o,
  output logic       fault_o,
  output logic [7:0] wrap_count_o
);

  localparam int unsigned CntW   = 3;
  localparam int unsigned PhaseW = 3;
  localparam int unsigned OhW    = 8;
  localparam int unsigned WrapW  = 8;

  localparam logic [1:0] StAcq    = 2'd0;
  localparam logic [1:0] StTrack  = 2'd1;
  localparam logic [1:0] StLocked = 2'd2;
  localparam logic [1:0] StFault  = 2'd3;

  function automatic logic is_legal(input logic [3:0] c);
    case (c)
      4'b0000, 4'b1000, 4'b1100, 4'b1110,
      4'b1111, 4'b0111, 4'b0011, 4'b0001: is_legal = 1'b1;
      default:                            is_legal = 1'b0;
    endcase
  endfunction

  // Illegal codes map to phase 0; Phase_onehot masks them out.
  function automatic logic [PhaseW-1:0] phase_of(input logic [3:0] c);
    case (c)
      4'b1000: phase_of = 3'd1;
      4'b1100: phase_of = 3'd2;
      4'b1110: phase_of = 3'd3;
      4'b1111: phase_of = 3'd4;
      4'b0111: phase_of = 3'd5;
      4'b0011: phase_of = 3'd6;
      4'b0001: phase_of = 3'd7;
      default: phase_of = 3'd0;
    endcase
  endfunction

  logic [3:0]        cur_q, cur_d;
  logic              have_prev_q, have_prev_d;
  logic [CntW-1:0]   good_cnt_q, good_cnt_d;
  logic [1:0]        state_q, state_d;
  logic              valid_q, valid_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [OhW-1:0]    onehot_q, onehot_d;
  logic              illegal_q, illegal_d;
  logic              seq_err_q, seq_err_d;
  logic              lock_q, lock_d;
  logic              fault_q, fault_d;

  logic [3:0] succ;
  logic       in_legal, cur_legal, compare, good_trans, err_trans;

  always_comb begin
    succ       = {~cur_q[0], cur_q[3:1]};
    in_legal   = is_legal(count_i);
    cur_legal  = is_legal(cur_q);
    compare    = have_prev_q && cur_legal;
    good_trans = enable_i && compare && (count_i == succ);
    err_trans  = enable_i && (!in_legal || (compare && (count_i != succ)));

    cur_d       = cur_q;
    have_prev_d = 1'b0;
    good_cnt_d  = good_cnt_q;
    state_d     = state_q;
    valid_d     = valid_q;
    phase_d     = phase_q;
    onehot_d    = onehot_q;
    illegal_d   = illegal_q;
    seq_err_d   = 1'b0;

    if (enable_i) begin
      cur_d       = count_i;
      have_prev_d = 1'b1;
      valid_d     = 1'b1;
      phase_d     = phase_of(count_i);
      onehot_d    = in_legal ? (OhW'(1) << phase_of(count_i)) : '0;
      illegal_d   = !in_legal;
      seq_err_d   = in_legal && compare && (count_i != succ);
    end

    case (state_q)
      StAcq: begin
        if (enable_i && in_legal) begin
          state_d    = StTrack;
          good_cnt_d = '0;
        end
      end
      StTrack: begin
        if (!enable_i || err_trans) begin
          state_d    = StAcq;
          good_cnt_d = '0;
        end else if (good_trans) begin
          if (good_cnt_q == CntW'(7)) begin
            state_d    = StLocked;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + CntW'(1);
          end
        end
      end
      StLocked: begin
        if (err_trans) state_d = StFault;
      end
      default: ;
    endcase

    // Clear overrides whatever transition the capture requested.
    if (clear_i) begin
      state_d    = StAcq;
      good_cnt_d = '0;
    end

    lock_d  = (state_d == StLocked);
    fault_d = (state_d == StFault);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cur_q       <= '0;
      have_prev_q <= 1'b0;
      good_cnt_q  <= '0;
      state_q     <= StAcq;
      valid_q     <= 1'b0;
      phase_q     <= '0;
      onehot_q    <= '0;
      illegal_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      lock_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      cur_q       <= cur_d;
      have_prev_q <= have_prev_d;
      good_cnt_q  <= good_cnt_d;
      state_q     <= state_d;
      valid_q     <= valid_d;
      phase_q     <= phase_d;
      onehot_q    <= onehot_d;
      illegal_q   <= illegal_d;
      seq_err_q   <= seq_err_d;
      lock_q      <= lock_d;
      fault_q     <= fault_d;
    end
  end

`ifdef JOHNSON_PHASE_MONITOR_WRAPCNT_EN
  logic [WrapW-1:0] wrap_q, wrap_d;

  // One revolution completes on the good 0001 -> 0000 step.
  always_comb begin
    wrap_d = wrap_q;
    if (clear_i)                              wrap_d = '0;
    else if (good_trans && count_i == 4'b0000) wrap_d = wrap_q + WrapW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) wrap_q <= '0;
    else          wrap_q <= wrap_d;
  end

  assign wrap_count_o = wrap_q;
`else
  assign wrap_count_o = {WrapW{1'b0}};
`endif

  assign valid_o        = valid_q;
  assign phase_o        = phase_q;
  assign phase_onehot_o = onehot_q;
  assign illegal_o      = illegal_q;
  assign seq_err_o      = seq_err_q;
  assign lock_o         = lock_q;
  assign fault_o        = fault_q;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Bench for johnson_phase_monitor: table-driven behavioural model plus directed and random stimulus.
module tb_johnson_phase_monitor;

  localparam logic [3:0] SEQ [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                                     4'b1111, 4'b0111, 4'b0011, 4'b0001};
  localparam logic [1:0] M_ACQ = 2'd0, M_TRACK = 2'd1, M_LOCKED = 2'd2, M_FAULT = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [3:0] cur;
    logic       have_prev;
    logic [3:0] good;
    logic [1:0] st;
    logic       seq_err;
    logic [7:0] wrap;
  } mstate_t;

  logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0, clear = 1'b0;
  logic [3:0] count = 4'b0000;
  logic       valid_o, illegal_o, seq_err_o, lock_o, fault_o;
  logic [2:0] phase_o;
  logic [7:0] phase_onehot_o, wrap_count_o;

  int n_cmp = 0, n_fail = 0;
  mstate_t m;
  logic [3:0] last_code;

  johnson_phase_monitor dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .clear_i(clear), .count_i(count),
    .valid_o(valid_o), .phase_o(phase_o), .phase_onehot_o(phase_onehot_o),
    .illegal_o(illegal_o), .seq_err_o(seq_err_o), .lock_o(lock_o), .fault_o(fault_o),
    .wrap_count_o(wrap_count_o)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(input logic [3:0] c);
    for (int i = 0; i < 8; i++) if (SEQ[3'(i)] == c) return i;
    return -1;
  endfunction

  // Reference behaviour written from the phase table, not from bit tricks.
  function automatic mstate_t model_next(input mstate_t s, input logic en, input logic clr,
                                         input logic [3:0] code);
    mstate_t n;
    int ci, ii;
    logic chk_ok, good, err, legal_in;
    n = s;
    ci = idx_of(s.cur);
    ii = idx_of(code);
    legal_in = (ii >= 0);
    chk_ok = s.have_prev && (ci >= 0);
    good = chk_ok && (code == SEQ[3'(ci + 1)]);
    err = !legal_in || (chk_ok && !good);
    if (en) begin
      n.cur = code;
      n.valid = 1'b1;
      n.have_prev = 1'b1;
      n.seq_err = chk_ok && !good && legal_in;
      case (s.st)
        M_ACQ: if (legal_in) begin n.st = M_TRACK; n.good = 4'd0; end
        M_TRACK: begin
          if (err) begin n.st = M_ACQ; n.good = 4'd0; end
          else if (good) begin
            n.good = s.good + 4'd1;
            if (n.good == 4'd8) n.st = M_LOCKED;
          end
        end
        M_LOCKED: if (err) n.st = M_FAULT;
        default: ;
      endcase
`ifdef JOHNSON_PHASE_MONITOR_WRAPCNT_EN
      if (good && code == SEQ[0]) n.wrap = s.wrap + 8'd1;
`endif
    end else begin
      n.have_prev = 1'b0;
      n.seq_err = 1'b0;
      if (s.st == M_TRACK) begin n.st = M_ACQ; n.good = 4'd0; end
    end
    if (clr) begin
      n.st = M_ACQ;
      n.good = 4'd0;
      n.wrap = 8'd0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_next(m, enable, clear, count);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int ci;
    ci = idx_of(m.cur);
    chk("valid", 8'(valid_o), 8'(m.valid));
    if (ci >= 0) chk("phase", 8'(phase_o), 8'(ci));
    chk("onehot", phase_onehot_o, (m.valid && ci >= 0) ? (8'(1) << ci) : 8'h00);
    chk("illegal", 8'(illegal_o), 8'(ci < 0));
    chk("seq_err", 8'(seq_err_o), 8'(m.seq_err));
    chk("lock", 8'(lock_o), 8'(m.st == M_LOCKED));
    chk("fault", 8'(fault_o), 8'(m.st == M_FAULT));
`ifdef JOHNSON_PHASE_MONITOR_WRAPCNT_EN
    chk("wrap", wrap_count_o, m.wrap);
`else
    chk("wrap", wrap_count_o, 8'h00);
`endif
  endtask

  task automatic step(input logic en, input logic clr, input logic [3:0] code);
    enable = en;
    clear = clr;
    count = code;
    if (en) last_code = code;
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    last_code = 4'b0000;
    // reset and idle
    repeat (3) begin @(posedge clk); #1; check_all(); end
    rst_n = 1'b1;
    repeat (5) step(1'b0, 1'b0, 4'b0000);
    chk("idle_valid", 8'(valid_o), 8'h00);

    // acquire and lock
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0, SEQ[3'(i)]);
      if (i == 7) begin
        chk("acq_phase7", 8'(phase_o), 8'd7);
        chk("acq_oh7", phase_onehot_o, 8'h80);
        chk("acq_nolock", 8'(lock_o), 8'h00);
      end
    end
    chk("acq_lock", 8'(lock_o), 8'h01);
    chk("acq_oh0", phase_onehot_o, 8'h01);
`ifdef JOHNSON_PHASE_MONITOR_WRAPCNT_EN
    chk("acq_wrap1", wrap_count_o, 8'h01);
`endif

    // sequence error while locked, then clear
    step(1'b1, 1'b0, 4'b1000);
    step(1'b1, 1'b0, 4'b1100);
    step(1'b1, 1'b0, 4'b1111);
    chk("skip_seqerr", 8'(seq_err_o), 8'h01);
    chk("skip_fault", 8'(fault_o), 8'h01);
    chk("skip_lock", 8'(lock_o), 8'h00);
    step(1'b0, 1'b1, 4'b0000);
    chk("clr_fault", 8'(fault_o), 8'h00);
    chk("clr_seqerr", 8'(seq_err_o), 8'h00);

    // illegal code in TRACK, then relock
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, SEQ[3'(i)]);
    step(1'b1, 1'b0, 4'b0101);
    chk("ill_flag", 8'(illegal_o), 8'h01);
    chk("ill_oh", phase_onehot_o, 8'h00);
    chk("ill_seqerr", 8'(seq_err_o), 8'h00);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, SEQ[3'(i)]);
    chk("relock", 8'(lock_o), 8'h01);

    // enable gap while locked
    repeat (3) step(1'b0, 1'b0, 4'b1010);
    step(1'b1, 1'b0, 4'b0011);
    chk("gap_seqerr", 8'(seq_err_o), 8'h00);
    chk("gap_lock", 8'(lock_o), 8'h01);

    // randomized traffic, mostly legal successors
    for (int i = 0; i < 600; i++) begin
      logic en, clr;
      logic [3:0] code;
      int li;
      en = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 40) == 0);
      li = idx_of(last_code);
      if ($urandom_range(0, 9) < 8) code = (li >= 0) ? SEQ[3'(li + 1)] : SEQ[0];
      else code = 4'($urandom_range(0, 15));
      step(en, clr, code);
    end

    // long run: 256 revolutions bring the wrap counter back to zero
    step(1'b0, 1'b1, 4'b0000);
    for (int i = 0; i <= 2048; i++) begin
      step(1'b1, 1'b0, SEQ[3'(i)]);
`ifdef JOHNSON_PHASE_MONITOR_WRAPCNT_EN
      if (i == 8) chk("wrap_one", wrap_count_o, 8'h01);
`endif
    end
    chk("wrap_lock", 8'(lock_o), 8'h01);
    chk("wrap_zero", wrap_count_o, 8'h00);

    // asynchronous reset mid-sequence
    step(1'b1, 1'b0, SEQ[1]);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 8'(valid_o), 8'h00);
    chk("arst_phase", 8'(phase_o), 8'h00);
    chk("arst_oh", phase_onehot_o, 8'h00);
    chk("arst_lock", 8'(lock_o), 8'h00);
    chk("arst_wrap", wrap_count_o, 8'h00);
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    step(1'b1, 1'b0, 4'b0111);
    chk("post_rst_seqerr", 8'(seq_err_o), 8'h00);
    step(1'b1, 1'b0, 4'b0011);
    step(1'b1, 1'b0, 4'b1100);
    chk("post_rst_skip", 8'(seq_err_o), 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
